sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM master port between two requesters.
  - Requester 0: training/input matrix loader (mostly writes).
  - Requester 1: kNN inference engine (mostly reads).
- Round-robin arbitration, exactly one outstanding transaction at a time.
- Address and write data are captured at grant, so requesters are decoupled from the SDRAM wait-states.

Parameters:
- W, 16, data word width.
- ADDR_W, 25, SDRAM address width.
- TIMEOUT, 64, watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- r0_read / r0_write  in  1 each  requester 0 strobes; held until r0_ack.
- r0_address  in  ADDR_W  requester 0 address.
- r0_writedata  in  W  requester 0 write data.
- r0_readdata  out  W  last read word returned to requester 0.
- r0_ack  out  1  one-cycle completion pulse to requester 0.
- r1_read, r1_write, r1_address, r1_writedata, r1_readdata, r1_ack: same as r0_* for requester 1.
- read  out  1  SDRAM read strobe.
- readaddress  out  ADDR_W  SDRAM read address.
- readdata  in  W  SDRAM read data.
- readdatavalid  in  1  readdata valid this cycle.
- write  out  1  SDRAM write strobe.
- writeaddress  out  ADDR_W  SDRAM write address.
- writedata  out  W  SDRAM write data.
- waitrequest  in  1  SDRAM stall; a strobe is accepted at a posedge where it is high and waitrequest is low.
- busy  out  1  high in any state other than IDLE.
- grant  out  1  index of current/last granted requester.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset values: all outputs 0; last_grant = 1, so requester 0 wins the first tie.
- FSM states: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE:
  - Request of requester i = ri_read | ri_write.
  - Both requesting: grant the requester not equal to last_grant. One requesting: grant it.
  - At the grant edge, capture address, writedata and op into internal registers; set grant; go ISSUE.
  - ri_write has priority over ri_read if both are high; the read is ignored for that transaction.
  - readdatavalid is ignored in IDLE.
- ISSUE:
  - Drive read or write from the captured op; drive readaddress/writeaddress/writedata from the captured registers.
  - Unused address output holds its last value.
  - Write accepted (waitrequest=0): drop strobe at that edge; go DONE.
  - Read accepted: drop strobe; go WAIT_RD.
  - If readdatavalid is also high in the accept cycle: capture readdata; go DONE directly.
- WAIT_RD: on readdatavalid, capture readdata into r<grant>_readdata; go DONE.
- DONE:
  - r<grant>_ack = 1 for exactly this cycle.
  - last_grant <= grant; go IDLE.
  - Requester must drop its strobe at the edge ending DONE; a strobe still high in IDLE is a new request.
- Latency:
  - Request high at edge k → strobe high in cycle k+1.
  - Minimum write: 3 cycles request-to-ack, ack in cycle k+2.
  - Minimum read: 4 cycles (or 3 if readdatavalid arrives with acceptance).
- Other rules:
  - ri_readdata changes only on requester i's read completion; it holds otherwise.
  - Requester inputs changing after grant have no effect on the transaction in flight.
  - Back-to-back requests from both requesters strictly alternate.
- Reset mid-transaction:
  - Strobes and acks drop at the reset edge; FSM goes to IDLE.
  - A readdatavalid arriving later is ignored; no ack is issued.

Optional Feature:
- Macro ARB_TIMEOUT_EN, enabled:
  - Counter cleared on entry to ISSUE; increments each cycle in ISSUE/WAIT_RD.
  - When count reaches TIMEOUT-1 without completion: drop strobe, go DONE, pulse timeout_err together with the ack.
  - ri_readdata is unchanged on abort.
- Disabled:
  - No counter; the FSM waits indefinitely.
  - timeout_err is tied 0.

Test Plan:
- Single write: r0_write, address 0x40, data 0x1234, waitrequest low → write high 1 cycle, writeaddress 0x40, writedata 0x1234; r0_ack 2 cycles after the request edge.
- Read with wait-states: r1_read at 0x960, waitrequest high 3 cycles, readdatavalid 2 cycles after accept with readdata 0xBEEF → r1_readdata = 0xBEEF; one r1_ack; r0_ack stays 0.
- Contention: both requesters issue 4 requests each, continuously → grants strictly 0,1,0,1,…, starting with 0; 8 acks total.
- Input change after grant: r0_address changed from 0x10 to 0x20 while waitrequest is high → SDRAM sees 0x10.
- Reset during WAIT_RD: rst for 1 cycle, then readdatavalid → no ack; busy = 0; r1_readdata = 0.
- With ARB_TIMEOUT_EN and TIMEOUT=8: waitrequest stuck high → strobe drops, ack and timeout_err pulse together at cycle 8 after the ISSUE entry.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM master port between two requesters, one transaction in flight.
// Optional watchdog abort is compiled in with `define ARB_TIMEOUT_EN.
module sdram_port_arbiter #(
   parameter int W       = 16,
   parameter int ADDR_W  = 25,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_read,
   input  logic              r0_write,
   input  logic [ADDR_W-1:0] r0_address,
   input  logic [W-1:0]      r0_writedata,
   output logic [W-1:0]      r0_readdata,
   output logic              r0_ack,
   input  logic              r1_read,
   input  logic              r1_write,
   input  logic [ADDR_W-1:0] r1_address,
   input  logic [W-1:0]      r1_writedata,
   output logic [W-1:0]      r1_readdata,
   output logic              r1_ack,
   output logic              read,
   output logic [ADDR_W-1:0] readaddress,
   input  logic [W-1:0]      readdata,
   input  logic              readdatavalid,
   output logic              write,
   output logic [ADDR_W-1:0] writeaddress,
   output logic [W-1:0]      writedata,
   input  logic              waitrequest,
   output logic              busy,
   output logic              grant,
   output logic              timeout_err
);
   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_RD = 2'd2, DONE = 2'd3} state_t;

   if (TIMEOUT < 2) begin : g_timeout_check
      $error("sdram_port_arbiter: TIMEOUT must be at least 2");
   end

   state_t            r_state;
   logic              r_last_grant, r_grant, r_is_write, r_read, r_write, r_busy, r_ack0, r_ack1;
   logic [ADDR_W-1:0] r_rd_addr, r_wr_addr;
   logic [W-1:0]      r_wr_data, r_rdata0, r_rdata1;

   logic              w_req0, w_req1, w_pick, w_sel_wr, w_accept, w_abort;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [W-1:0]      w_sel_data;

   assign w_req0     = r0_read | r0_write;
   assign w_req1     = r1_read | r1_write;
   assign w_sel_wr   = w_pick ? r1_write : r0_write;
   assign w_sel_addr = w_pick ? r1_address : r0_address;
   assign w_sel_data = w_pick ? r1_writedata : r0_writedata;
   assign w_accept   = (r_read | r_write) & ~waitrequest;

   // Round-robin pick: on a tie the requester that did not go last wins.
   always_comb begin
      w_pick = 1'b0;
      if (w_req0 && w_req1) begin
         w_pick = ~r_last_grant;
      end else if (w_req1) begin
         w_pick = 1'b1;
      end else begin
         w_pick = 1'b0;
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   logic [CNT_W-1:0] r_count;
   logic             r_timeout_err;
   logic             w_done;

   assign w_done  = ((r_state == ISSUE) && w_accept && (r_is_write || readdatavalid)) ||
                    ((r_state == WAIT_RD) && readdatavalid);
   assign w_abort = ((r_state == ISSUE) || (r_state == WAIT_RD)) &&
                    (r_count == CNT_W'(TIMEOUT - 1)) && !w_done;
   assign timeout_err = r_timeout_err;

   // Watchdog: cycles spent waiting on the SDRAM, zero in the first ISSUE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count       <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= w_abort;
         if ((r_state == ISSUE) || (r_state == WAIT_RD)) begin
            r_count <= r_count + CNT_W'(1);
         end else begin
            r_count <= '0;
         end
      end
   end
`else
   assign w_abort     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // Transaction FSM with all port-facing outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;
         r_grant      <= 1'b0;
         r_is_write   <= 1'b0;
         r_read       <= 1'b0;
         r_write      <= 1'b0;
         r_busy       <= 1'b0;
         r_ack0       <= 1'b0;
         r_ack1       <= 1'b0;
         r_rd_addr    <= '0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_rdata0     <= '0;
         r_rdata1     <= '0;
      end else begin
         r_ack0 <= 1'b0;
         r_ack1 <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_req0 || w_req1) begin
                  r_grant    <= w_pick;
                  r_busy     <= 1'b1;
                  r_is_write <= w_sel_wr;
                  r_state    <= ISSUE;
                  if (w_sel_wr) begin
                     r_write   <= 1'b1;
                     r_wr_addr <= w_sel_addr;
                     r_wr_data <= w_sel_data;
                  end else begin
                     r_read    <= 1'b1;
                     r_rd_addr <= w_sel_addr;
                  end
               end
            end
            ISSUE: begin
               if (w_abort || w_accept) begin
                  r_read  <= 1'b0;
                  r_write <= 1'b0;
               end
               if (w_abort || (w_accept && (r_is_write || readdatavalid))) begin
                  r_state <= DONE;
                  r_ack0  <= ~r_grant;
                  r_ack1  <= r_grant;
                  if (!w_abort && !r_is_write) begin
                     if (r_grant) r_rdata1 <= readdata;
                     else         r_rdata0 <= readdata;
                  end
               end else if (w_accept) begin
                  r_state <= WAIT_RD;
               end
            end
            WAIT_RD: begin
               if (w_abort || readdatavalid) begin
                  r_state <= DONE;
                  r_ack0  <= ~r_grant;
                  r_ack1  <= r_grant;
                  if (!w_abort) begin
                     if (r_grant) r_rdata1 <= readdata;
                     else         r_rdata0 <= readdata;
                  end
               end
            end
            DONE: begin
               r_last_grant <= r_grant;
               r_busy       <= 1'b0;
               r_state      <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_read  <= 1'b0;
               r_write <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign read         = r_read;
   assign write        = r_write;
   assign readaddress  = r_rd_addr;
   assign writeaddress = r_wr_addr;
   assign writedata    = r_wr_data;
   assign r0_readdata  = r_rdata0;
   assign r1_readdata  = r_rdata1;
   assign r0_ack       = r_ack0;
   assign r1_ack       = r_ack1;
   assign busy         = r_busy;
   assign grant        = r_grant;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: directed stimulus queues expectations, a negedge monitor checks them.
module tb_sdram_port_arbiter;
   localparam int W = 16;
   localparam int ADDR_W = 25;

   logic              clk = 1'b0;
   logic              rst;
   logic              r0_read, r0_write, r1_read, r1_write;
   logic [ADDR_W-1:0] r0_address, r1_address;
   logic [W-1:0]      r0_writedata, r1_writedata, r0_readdata, r1_readdata;
   logic              r0_ack, r1_ack;
   logic              read, write, readdatavalid, waitrequest;
   logic [ADDR_W-1:0] readaddress, writeaddress;
   logic [W-1:0]      readdata, writedata;
   logic              busy, grant, timeout_err;

   sdram_port_arbiter #(.W(W), .ADDR_W(ADDR_W), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .r0_read(r0_read), .r0_write(r0_write), .r0_address(r0_address),
      .r0_writedata(r0_writedata), .r0_readdata(r0_readdata), .r0_ack(r0_ack),
      .r1_read(r1_read), .r1_write(r1_write), .r1_address(r1_address),
      .r1_writedata(r1_writedata), .r1_readdata(r1_readdata), .r1_ack(r1_ack),
      .read(read), .readaddress(readaddress), .readdata(readdata),
      .readdatavalid(readdatavalid), .write(write), .writeaddress(writeaddress),
      .writedata(writedata), .waitrequest(waitrequest), .busy(busy),
      .grant(grant), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct { logic is_wr; logic [ADDR_W-1:0] addr; logic [W-1:0] data; } bus_t;
   typedef struct { logic req; logic [W-1:0] rdata; logic terr; } ack_t;

   bus_t q_bus[$];
   ack_t q_ack[$];
   int   checks = 0;
   int   failures = 0;
   int   acks_seen = 0;
   bit   auto_mem = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_bus(input logic is_wr, input logic [31:0] addr, input logic [31:0] data);
      bus_t b;
      b.is_wr = is_wr;
      b.addr  = addr[ADDR_W-1:0];
      b.data  = data[W-1:0];
      q_bus.push_back(b);
   endtask

   task automatic push_ack(input logic req, input logic [31:0] rdata, input logic terr);
      ack_t a;
      a.req   = req;
      a.rdata = rdata[W-1:0];
      a.terr  = terr;
      q_ack.push_back(a);
   endtask

   function automatic logic [W-1:0] mem_word(input logic [ADDR_W-1:0] a);
      return a[W-1:0] ^ 16'hC3C3;
   endfunction

   // Monitor: every accepted SDRAM strobe and every ack is matched against the scoreboard.
   initial begin
      bus_t eb;
      ack_t ea;
      forever begin
         @(negedge clk);
         if (!rst && (read || write) && !waitrequest) begin
            if (q_bus.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL bus_unexpected: got read=%0b write=%0b with nothing expected", read, write);
            end else begin
               eb = q_bus.pop_front();
               check("bus_op", 32'(write), 32'(eb.is_wr));
               check("bus_addr", 32'(eb.is_wr ? writeaddress : readaddress), 32'(eb.addr));
               if (eb.is_wr) check("bus_wdata", 32'(writedata), 32'(eb.data));
            end
         end
         if (r0_ack || r1_ack) begin
            acks_seen++;
            if (q_ack.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL ack_unexpected: got r0_ack=%0b r1_ack=%0b with nothing expected", r0_ack, r1_ack);
            end else begin
               ea = q_ack.pop_front();
               check("ack_owner", 32'(r1_ack), 32'(ea.req));
               check("ack_single", 32'(r0_ack & r1_ack), 32'd0);
               check("ack_rdata", 32'(ea.req ? r1_readdata : r0_readdata), 32'(ea.rdata));
               check("ack_terr", 32'(timeout_err), 32'(ea.terr));
            end
         end
      end
   end

   // SDRAM responder for the contention run: read data one cycle after acceptance.
   initial begin
      logic [ADDR_W-1:0] pa;
      forever begin
         @(negedge clk);
         if (auto_mem && read && !waitrequest) begin
            pa = readaddress;
            tick();
            readdata      = mem_word(pa);
            readdatavalid = 1'b1;
            tick();
            readdatavalid = 1'b0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      int base_acks;
      rst = 1'b1;
      {r0_read, r0_write, r1_read, r1_write} = 4'b0000;
      r0_address = '0; r1_address = '0; r0_writedata = '0; r1_writedata = '0;
      readdata = '0; readdatavalid = 1'b0; waitrequest = 1'b0;
      tick(); tick(); tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_strobes", 32'({read, write}), 32'd0);
      check("rst_acks", 32'({r0_ack, r1_ack, timeout_err}), 32'd0);
      check("rst_rdata", 32'({r0_readdata, r1_readdata}), 32'd0);
      check("rst_addr", 32'(readaddress | writeaddress), 32'd0);
      rst = 1'b0;

      // single write, minimum latency
      push_bus(1'b1, 32'h40, 32'h1234);
      push_ack(1'b0, 32'h0, 1'b0);
      r0_write = 1'b1; r0_address = 25'h40; r0_writedata = 16'h1234;
      tick();
      check("wr_strobe", 32'(write), 32'd1);
      check("wr_busy_grant", 32'({busy, grant}), 32'b10);
      tick();
      check("wr_ack_k2", 32'(r0_ack), 32'd1);
      check("wr_strobe_drop", 32'(write), 32'd0);
      r0_write = 1'b0;
      tick();
      check("wr_ack_pulse", 32'({r0_ack, busy}), 32'd0);

      // read with three wait-states, data two cycles after accept
      push_bus(1'b0, 32'h960, 32'h0);
      push_ack(1'b1, 32'hBEEF, 1'b0);
      r1_read = 1'b1; r1_address = 25'h960; waitrequest = 1'b1;
      tick();
      check("rd_grant", 32'(grant), 32'd1);
      for (int i = 0; i < 3; i++) begin
         check("rd_strobe_held", 32'({read, readaddress}), 32'({1'b1, 25'h960}));
         tick();
      end
      waitrequest = 1'b0;
      tick();
      check("rd_wait_state", 32'({read, busy}), 32'b01);
      tick();
      readdata = 16'hBEEF; readdatavalid = 1'b1;
      tick();
      readdatavalid = 1'b0; r1_read = 1'b0;
      check("rd_ack", 32'({r0_ack, r1_ack}), 32'b01);
      check("rd_data", 32'(r1_readdata), 32'hBEEF);
      tick();

      // readdatavalid in IDLE is ignored
      readdata = 16'hFFFF; readdatavalid = 1'b1;
      tick();
      readdatavalid = 1'b0;
      check("idle_rdv_ignored", 32'({r0_readdata, r1_readdata}), 32'h0000BEEF);

      // read completing in the acceptance cycle
      push_bus(1'b0, 32'h123, 32'h0);
      push_ack(1'b0, 32'h5A5A, 1'b0);
      r0_read = 1'b1; r0_address = 25'h123;
      tick();
      readdata = 16'h5A5A; readdatavalid = 1'b1;
      tick();
      readdatavalid = 1'b0; r0_read = 1'b0;
      check("fast_rd_ack", 32'(r0_ack), 32'd1);
      check("fast_rd_data", 32'({r0_readdata, r1_readdata}), 32'h5A5ABEEF);
      tick();

      // write wins over read on the same requester
      push_bus(1'b1, 32'h77, 32'h0F0F);
      push_ack(1'b0, 32'h5A5A, 1'b0);
      r0_read = 1'b1; r0_write = 1'b1; r0_address = 25'h77; r0_writedata = 16'h0F0F;
      tick();
      check("wr_prio", 32'({read, write}), 32'b01);
      tick();
      r0_read = 1'b0; r0_write = 1'b0;
      tick();

      // contention from reset: strict alternation starting with requester 0
      rst = 1'b1;
      tick();
      check("rst2_state", 32'({busy, read, write, r0_readdata, r1_readdata}), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push_bus(1'b1, 32'h100 + 32'(i), 32'hA000 + 32'(i));
         push_ack(1'b0, 32'h0, 1'b0);
         push_bus(1'b0, 32'h200 + 32'(i), 32'h0);
         push_ack(1'b1, 32'(mem_word(25'(32'h200 + 32'(i)))), 1'b0);
      end
      base_acks = acks_seen;
      auto_mem = 1'b1;
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               int c;
               r0_write = 1'b1; r0_address = 25'(32'h100 + 32'(i)); r0_writedata = 16'(32'hA000 + 32'(i));
               c = 0;
               do begin tick(); c++; end while (!r0_ack && c < 100);
               check("cont_r0_ack", 32'(r0_ack), 32'd1);
            end
            r0_write = 1'b0;
         end
         begin
            for (int j = 0; j < 4; j++) begin
               int c;
               r1_read = 1'b1; r1_address = 25'(32'h200 + 32'(j));
               c = 0;
               do begin tick(); c++; end while (!r1_ack && c < 100);
               check("cont_r1_ack", 32'(r1_ack), 32'd1);
            end
            r1_read = 1'b0;
         end
      join
      auto_mem = 1'b0;
      tick();
      check("cont_ack_count", 32'(acks_seen - base_acks), 32'd8);

      // requester inputs changing after grant do not reach the SDRAM
      push_bus(1'b1, 32'h10, 32'h1111);
      push_ack(1'b0, 32'h0, 1'b0);
      r0_write = 1'b1; r0_address = 25'h10; r0_writedata = 16'h1111; waitrequest = 1'b1;
      tick();
      r0_address = 25'h20; r0_writedata = 16'h2222;
      tick();
      check("capt_addr", 32'(writeaddress), 32'h10);
      tick();
      waitrequest = 1'b0;
      tick();
      check("capt_ack", 32'(r0_ack), 32'd1);
      r0_write = 1'b0;
      tick();

      // reset in WAIT_RD: late readdatavalid must not complete anything
      push_bus(1'b0, 32'h333, 32'h0);
      r1_read = 1'b1; r1_address = 25'h333;
      tick();
      tick();
      check("rstrd_wait", 32'({busy, read}), 32'b10);
      rst = 1'b1; r1_read = 1'b0;
      tick();
      rst = 1'b0;
      check("rstrd_after", 32'({busy, read, r1_ack, r1_readdata}), 32'd0);
      readdata = 16'hDEAD; readdatavalid = 1'b1;
      tick();
      readdatavalid = 1'b0;
      check("rstrd_no_ack", 32'({r1_ack, r1_readdata}), 32'd0);
      tick();
      check("rstrd_idle", 32'({busy, r0_ack, r1_ack}), 32'd0);

`ifdef ARB_TIMEOUT_EN
      // watchdog abort with waitrequest stuck high
      push_ack(1'b0, 32'h0, 1'b1);
      r0_read = 1'b1; r0_address = 25'h44; waitrequest = 1'b1;
      tick();
      for (int c = 1; c < 8; c++) begin
         tick();
         check("to_hold", 32'({read, r0_ack, timeout_err}), 32'b100);
      end
      tick();
      check("to_abort", 32'({read, r0_ack, timeout_err}), 32'b011);
      r0_read = 1'b0; waitrequest = 1'b0;
      tick();
      check("to_pulse", 32'({timeout_err, r0_ack, busy}), 32'd0);
`endif

      tick(); tick(); tick();
      check("sb_bus_empty", 32'(q_bus.size()), 32'd0);
      check("sb_ack_empty", 32'(q_ack.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
